// File: rtl/mem_ls_pkg.sv
// Shared types for the load/store port scheduler.
package mem_ls_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first request after 'last'.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [LW-1:0] idx;

  // Scan last+1 .. last+N (mod N); the previous owner gets lowest priority.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = LW'((32'(last) + k) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_ls_sched.sv
// Shares one load/store memory port between NREQ requesters, one transaction
// outstanding at a time, with round-robin arbitration and a WAIT-state timeout.
module mem_ls_sched
  import mem_ls_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    resp_valid,
  output logic               resp_err,
  output logic [DW-1:0]      resp_rdata,
  output logic               busy,
  output logic               mem_l_valid,
  output logic               mem_s_valid,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic               mem_load_finish,
  input  logic               mem_store_finish,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int unsigned     LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  state_t           state, state_d;
  logic [LW-1:0]    last_grant, last_grant_d;
  logic [LW-1:0]    owner, owner_d;
  logic             we, we_d;
  logic [CNT_W-1:0] cnt, cnt_d;

  logic [NREQ-1:0]  req_ready_d, resp_valid_d;
  logic             resp_err_d, busy_d, mem_l_valid_d, mem_s_valid_d;
  logic [DW-1:0]    resp_rdata_d, mem_wdata_d;
  logic [AW-1:0]    mem_addr_d;

  logic [NREQ-1:0]  gnt;
  logic [LW-1:0]    gnt_idx;
  logic             finish;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (gnt)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_idx = LW'(i);
    end
  end

  // Only the finish pulse matching the latched direction completes a transaction.
  assign finish = we ? mem_store_finish : mem_load_finish;

  always_comb begin
    state_d       = state;
    last_grant_d  = last_grant;
    owner_d       = owner;
    we_d          = we;
    cnt_d         = cnt;
    req_ready_d   = '0;
    resp_valid_d  = '0;
    resp_err_d    = 1'b0;
    resp_rdata_d  = '0;
    mem_l_valid_d = 1'b0;
    mem_s_valid_d = 1'b0;
    mem_addr_d    = mem_addr;
    mem_wdata_d   = mem_wdata;

    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready_d = gnt;
          owner_d     = gnt_idx;
          we_d        = req_we[gnt_idx];
          mem_addr_d  = req_addr[32'(gnt_idx) * AW +: AW];
          mem_wdata_d = req_wdata[32'(gnt_idx) * DW +: DW];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        mem_l_valid_d = !we;
        mem_s_valid_d = we;
        cnt_d         = '0;
        state_d       = WAIT;
      end
      WAIT: begin
        cnt_d = cnt + CNT_W'(1);
        if (finish) begin
          resp_valid_d[owner] = 1'b1;
          resp_rdata_d        = we ? '0 : mem_rdata;
          state_d             = RESP;
        end else if (cnt_d == TO) begin
          resp_valid_d[owner] = 1'b1;
          resp_err_d          = 1'b1;
          state_d             = RESP;
        end
      end
      RESP: begin
        last_grant_d = owner;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      last_grant  <= LW'(NREQ - 1);
      owner       <= '0;
      we          <= 1'b0;
      cnt         <= '0;
      req_ready   <= '0;
      resp_valid  <= '0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
      busy        <= 1'b0;
      mem_l_valid <= 1'b0;
      mem_s_valid <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_d;
      last_grant  <= last_grant_d;
      owner       <= owner_d;
      we          <= we_d;
      cnt         <= cnt_d;
      req_ready   <= req_ready_d;
      resp_valid  <= resp_valid_d;
      resp_err    <= resp_err_d;
      resp_rdata  <= resp_rdata_d;
      busy        <= busy_d;
      mem_l_valid <= mem_l_valid_d;
      mem_s_valid <= mem_s_valid_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
    end
  end

endmodule

// File: tb/tb_mem_ls_sched.sv
// Bench for mem_ls_sched: cycle-stamped transaction model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_mem_ls_sched;

  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 12;

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ-1:0]    req_we = '0;
  logic [NREQ*AW-1:0] req_addr = '0;
  logic [NREQ*DW-1:0] req_wdata = '0;
  logic [NREQ-1:0]    req_ready, resp_valid;
  logic               resp_err, busy, mem_l_valid, mem_s_valid;
  logic [DW-1:0]      resp_rdata, mem_wdata;
  logic [AW-1:0]      mem_addr;
  logic               mem_load_finish = 1'b0;
  logic               mem_store_finish = 1'b0;
  logic [DW-1:0]      mem_rdata = '0;

  int          dly = 1;
  int          spur = 0;
  logic [31:0] rd_val = '0;
  bit          ld;

  int n_chk = 0;
  int n_err = 0;

  mem_ls_sched #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)) u_dut (
    .clk              (clk),
    .rstn             (rstn),
    .req_valid        (req_valid),
    .req_we           (req_we),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .req_ready        (req_ready),
    .resp_valid       (resp_valid),
    .resp_err         (resp_err),
    .resp_rdata       (resp_rdata),
    .busy             (busy),
    .mem_l_valid      (mem_l_valid),
    .mem_s_valid      (mem_s_valid),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_load_finish  (mem_load_finish),
    .mem_store_finish (mem_store_finish),
    .mem_rdata        (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory unit: answers k=dly cycles after the start pulse; optional wrong-type pulse at k=spur.
  always begin
    @(negedge clk);
    if (mem_l_valid || mem_s_valid) begin
      ld = mem_l_valid;
      for (int k = 1; k <= dly; k++) begin
        @(negedge clk);
        mem_rdata        = rd_val;
        mem_load_finish  = ld ? (k == dly) : (k == spur);
        mem_store_finish = ld ? (k == spur) : (k == dly);
      end
      @(negedge clk);
      mem_load_finish  = 1'b0;
      mem_store_finish = 1'b0;
      mem_rdata        = '0;
    end
  end

  // Transaction model: cycle stamps of accept and response, nothing else.
  int          cyc = 0;
  bit          m_active;
  int          m_acc, m_resp, m_free, m_owner, m_last, m_idx;
  bit          m_we, m_err, m_found;
  logic [31:0] m_addr, m_wdata, m_rdata;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_active = 1'b0;
      m_last   = NREQ - 1;
      m_free   = 0;
      m_resp   = -1;
      m_owner  = 0;
    end else begin
      cyc = cyc + 1;
      if (m_active && m_resp < 0 && cyc - 1 >= m_acc + 1) begin
        if (m_we ? mem_store_finish : mem_load_finish) begin
          m_resp  = cyc;
          m_err   = 1'b0;
          m_rdata = m_we ? 32'h0 : mem_rdata;
        end else if (cyc - 1 == m_acc + TO) begin
          m_resp  = cyc;
          m_err   = 1'b1;
          m_rdata = 32'h0;
        end
      end else if (m_active && m_resp >= 0 && cyc > m_resp) begin
        m_active = 1'b0;
        m_last   = m_owner;
        m_free   = cyc;
      end else if (!m_active && cyc - 1 >= m_free && req_valid != '0) begin
        m_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          m_idx = (m_last + k) % NREQ;
          if (!m_found && req_valid[m_idx]) begin
            m_found = 1'b1;
            m_owner = m_idx;
          end
        end
        m_active = 1'b1;
        m_acc    = cyc;
        m_resp   = -1;
        m_we     = req_we[m_owner];
        m_addr   = req_addr[m_owner*AW +: AW];
        m_wdata  = req_wdata[m_owner*DW +: DW];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  task automatic compare_cycle();
    logic [NREQ-1:0] oh;
    bit              at_resp;
    oh = '0;
    oh[m_owner] = 1'b1;
    at_resp = m_active && (cyc == m_resp);
    chk("req_ready",   req_ready,   (m_active && cyc == m_acc) ? oh : '0);
    chk("mem_l_valid", mem_l_valid, m_active && cyc == m_acc + 1 && !m_we);
    chk("mem_s_valid", mem_s_valid, m_active && cyc == m_acc + 1 && m_we);
    chk("mem_addr",    mem_addr,    m_active ? m_addr : 32'h0);
    chk("mem_wdata",   mem_wdata,   m_active ? m_wdata : 32'h0);
    chk("busy",        busy,        m_active);
    chk("resp_valid",  resp_valid,  at_resp ? oh : '0);
    chk("resp_err",    resp_err,    at_resp && m_err);
    chk("resp_rdata",  resp_rdata,  at_resp ? m_rdata : 32'h0);
  endtask

  task automatic tick();
    @(negedge clk);
    if (rstn) compare_cycle();
  endtask

  task automatic issue(input int r, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    req_valid[r] = 1'b1;
    req_we[r] = we;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (req_ready[r]) got = 1'b1;
    end
    req_valid[r] = 1'b0;
    chk("accept_seen", got, 1);
  endtask

  task automatic wait_resp(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      n++;
      if (|resp_valid) seen = 1'b1;
    end
    chk("resp_seen", seen, 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 30 && busy; n++) tick();
    chk("idle_reached", busy, 0);
  endtask

  initial begin
    int n, quiet, gi;
    int exp_seq[4];
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;

    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_addr", mem_addr, 0);
    rstn = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // Single load, memory answers at T+2
    dly = 1; spur = 0; rd_val = 32'hDEADBEEF;
    issue(0, 1'b0, 32'h100, 32'h0);
    chk("t1_ready", req_ready, 2'b01);
    tick();
    chk("t1_lvalid", mem_l_valid, 1);
    chk("t1_svalid", mem_s_valid, 0);
    chk("t1_addr", mem_addr, 32'h100);
    tick();
    chk("t1_noresp", resp_valid, 0);
    tick();
    chk("t1_resp", resp_valid, 2'b01);
    chk("t1_rdata", resp_rdata, 32'hDEADBEEF);
    chk("t1_err", resp_err, 0);
    wait_idle();

    // Store with 10-cycle latency and a spurious load_finish in WAIT
    dly = 10; spur = 4; rd_val = 32'h11112222;
    issue(1, 1'b1, 32'h400, 32'hA5A55A5A);
    chk("t3_ready", req_ready, 2'b10);
    wait_resp(n);
    chk("t3_latency", n, 12);
    chk("t3_resp", resp_valid, 2'b10);
    chk("t3_rdata", resp_rdata, 0);
    chk("t3_err", resp_err, 0);
    wait_idle();

    // No finish in time: timeout, then a late finish in IDLE
    dly = 20; spur = 0; rd_val = 32'h33334444;
    issue(0, 1'b0, 32'h500, 32'h0);
    wait_resp(n);
    chk("t4_latency", n, TO + 1);
    chk("t4_err", resp_err, 1);
    chk("t4_rdata", resp_rdata, 0);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (|resp_valid) quiet++;
    end
    chk("t4_late_quiet", quiet, 0);

    // Finish on the timeout cycle counts as success
    dly = TO - 1; spur = 0; rd_val = 32'hC0FFEE00;
    issue(1, 1'b0, 32'h600, 32'h0);
    wait_resp(n);
    chk("t6_latency", n, TO + 1);
    chk("t6_resp", resp_valid, 2'b10);
    chk("t6_err", resp_err, 0);
    chk("t6_rdata", resp_rdata, 32'hC0FFEE00);
    wait_idle();
    repeat (2) tick();

    // Reset during WAIT
    dly = 8; spur = 0; rd_val = 32'h55556666;
    issue(0, 1'b1, 32'h700, 32'h77);
    tick();
    tick();
    chk("t5_busy_pre", busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_wdata", mem_wdata, 0);
    chk("t5_svalid", mem_s_valid, 0);
    chk("t5_resp", resp_valid, 0);
    repeat (10) tick();
    rstn = 1'b1;

    // Two continuous requesters, mixed direction: grants alternate from requester 0
    dly = 1; spur = 0; rd_val = 32'h12345678;
    req_addr  = {32'h300, 32'h200};
    req_wdata = {32'hCAFE0001, 32'h0};
    req_we    = 2'b10;
    req_valid = 2'b11;
    for (int g = 0; g < 4; g++) begin
      bit got;
      got = 1'b0;
      gi = -1;
      for (int k = 0; k < 20 && !got; k++) begin
        tick();
        if (|req_ready) begin
          got = 1'b1;
          gi = req_ready[1] ? 1 : 0;
        end
      end
      chk("rr_grant", gi, exp_seq[g]);
    end
    req_valid = '0;
    wait_idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
